id_recv_buffer: RTL

//  Receiving end of the IF->ID fetch handshake. Accepts {pc, inst} from the

---
 rtl/id_recv_buffer.sv | 117 +++++++++++
 1 files changed

// File: rtl/id_recv_buffer.sv
// id_recv_buffer: receiving end of the IF->ID fetch handshake.
// Two-entry skid buffer (main + skid) between fetch and decode. ID_ready_o is
// decoded from the state flops only, so there is no combinational path from
// dec_ready_i or IF_valid_i back to the fetch stage. A flush empties it.
module id_recv_buffer #(
   parameter int PC_WIDTH   = 64,
   parameter int INST_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  IF_valid_i,
   input  logic [PC_WIDTH-1:0]   IF_pc_i,
   input  logic [INST_WIDTH-1:0] IF_inst_i,
   output logic                  ID_ready_o,
   input  logic                  id_flush_i,
   output logic                  dec_valid_o,
   output logic [PC_WIDTH-1:0]   dec_pc_o,
   output logic [INST_WIDTH-1:0] dec_inst_o,
   input  logic                  dec_ready_i,
   output logic [1:0]            occupancy_o
);

   // The state encoding doubles as the occupancy count.
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_e;

   state_e                state_q, state_d;
   logic [PC_WIDTH-1:0]   main_pc_q, main_pc_d;
   logic [INST_WIDTH-1:0] main_inst_q, main_inst_d;
   logic [PC_WIDTH-1:0]   skid_pc_q, skid_pc_d;
   logic [INST_WIDTH-1:0] skid_inst_q, skid_inst_d;

   logic accept;
   logic pop;

   // Handshake qualifiers; ready depends on state only, valid is gated by flush.
   assign ID_ready_o  = (state_q != FULL);
   assign dec_valid_o = (state_q != EMPTY) && !id_flush_i;
   assign accept      = IF_valid_i && ID_ready_o && !id_flush_i;
   assign pop         = dec_valid_o && dec_ready_i;

   // The decoder always sees the main register; skid only backs it up.
   assign dec_pc_o    = main_pc_q;
   assign dec_inst_o  = main_inst_q;
   assign occupancy_o = state_q;

   // Next-state and data-path selection for the main/skid pair.
   always_comb begin
      // NOTE: every _d gets a hold value first so no path leaves it unassigned,
      // which would otherwise infer a latch.
      state_d     = state_q;
      main_pc_d   = main_pc_q;
      main_inst_d = main_inst_q;
      skid_pc_d   = skid_pc_q;
      skid_inst_d = skid_inst_q;

      if (id_flush_i) begin
         // Flush wins over everything; stale data is left in place.
         state_d = EMPTY;
      end else begin
         unique case (state_q)
            EMPTY: begin
               if (accept) begin
                  state_d     = ONE;
                  main_pc_d   = IF_pc_i;
                  main_inst_d = IF_inst_i;
               end
            end
            ONE: begin
               if (accept && !pop) begin
                  state_d     = FULL;
                  skid_pc_d   = IF_pc_i;
                  skid_inst_d = IF_inst_i;
               end else if (pop && !accept) begin
                  state_d = EMPTY;
               end else if (accept && pop) begin
                  main_pc_d   = IF_pc_i;
                  main_inst_d = IF_inst_i;
               end
            end
            FULL: begin
               // ready is low here, so only the decoder side can move.
               if (pop) begin
                  state_d     = ONE;
                  main_pc_d   = skid_pc_q;
                  main_inst_d = skid_inst_q;
               end
            end
            default: state_d = EMPTY;
         endcase
      end
   end

   // State and data registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: the data registers are reset too so dec_pc_o/dec_inst_o read
         // zero out of reset instead of X.
         state_q     <= EMPTY;
         main_pc_q   <= '0;
         main_inst_q <= '0;
         skid_pc_q   <= '0;
         skid_inst_q <= '0;
      end else begin
         // NOTE: non-blocking so every flop samples the pre-edge values.
         state_q     <= state_d;
         main_pc_q   <= main_pc_d;
         main_inst_q <= main_inst_d;
         skid_pc_q   <= skid_pc_d;
         skid_inst_q <= skid_inst_d;
      end
   end

endmodule
